serial_full_subtractor: RTL and testbench
=========================================

// Module: serial_full_subtractor
// PURPOSE
//  Bit-serial subtractor; the inverse of the team's full-adder datapath cell.
//  Computes diff = a - b - borrow_in over WIDTH clocks, LSB first, through a
//  single full-subtractor cell and a borrow flop.
//  Used as the subtract unit in the multi-cycle ALU.
//  Ports: start/busy/done handshake.
// PARAMETERS
//  WIDTH   8   operand and result width in bits; must be >= 2
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      request; sampled only in IDLE or DONE
//  a           in   WIDTH  minuend, captured when start is accepted
//  b           in   WIDTH  subtrahend, captured when start is accepted
//  borrow_in   in   1      initial borrow, captured when start is accepted
//  busy        out  1      high while in SHIFT
//  done        out  1      one-cycle pulse: diff/borrow_out just became valid
//  diff        out  WIDTH  result; held stable from done until next accept
//  borrow_out  out  1      final borrow (1 => unsigned a < b + borrow_in)
//  overflow    out  1      signed overflow; present only with SERIAL_SUB_OVF_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE.
//    busy=0, done=0, diff=0, borrow_out=0, overflow=0.
//    Internal shift registers, counter and borrow flop are cleared.
//  - FSM states: IDLE, SHIFT, DONE.
//    - IDLE --start--> SHIFT: load a_sr=a, b_sr=b, bflop=borrow_in, cnt=0.
//    - SHIFT: each cycle uses x=a_sr[0], y=b_sr[0], c=bflop.
//      - d = x^y^c; bnext = (~x&y) | (~(x^y)&c).
//      - res_sr <= {d, res_sr[WIDTH-1:1]}; a_sr, b_sr shift right.
//      - bflop <= bnext; cnt++.
//      - When cnt==WIDTH-1: -> DONE.
//    - DONE: diff<=res_sr, borrow_out<=bflop, done=1 for exactly this cycle.
//      - start=1 here: accepted as in IDLE, next state SHIFT (back-to-back).
//      - Otherwise: -> IDLE.
//  - Latency: start accepted at edge N.
//    - busy=1 for cycles N+1 .. N+WIDTH.
//    - done=1 in cycle N+WIDTH+1.
//    - Throughput: one op per WIDTH+1 clocks.
//  - start while busy: ignored. Operands and borrow_in are not re-sampled.
//  - diff/borrow_out update only on entry to DONE; they hold their last
//    result through IDLE and SHIFT.
//  - Arithmetic is modulo 2^WIDTH: diff = (a - b - borrow_in) mod 2^WIDTH.
//  - Reset mid-operation: immediate abort to IDLE. All outputs return to
//    their reset values; the partial result is discarded.
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//    - Port overflow exists; updated with diff on entry to DONE.
//    - overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the
//      captured operands.
//  SERIAL_SUB_OVF_EN undefined:
//    - Port overflow and its logic are absent; all else identical.
// TESTING (WIDTH=8)
//  1. a=0x05 b=0x03 bin=0, start@N.
//     -> done@N+9, diff=0x02, borrow_out=0, busy high 8 cycles.
//  2. a=0x03 b=0x05 bin=0 -> diff=0xFE, borrow_out=1, overflow=0.
//  3. a=0x80 b=0x01 bin=0 -> diff=0x7F, borrow_out=0, overflow=1 (macro on).
//  4. a=0x00 b=0x00 bin=1 -> diff=0xFF, borrow_out=1.
//     Then start held high in the DONE cycle with a=0x10 b=0x01
//     -> next done 9 cycles later, diff=0x0F.
//  5. start pulses at cycles 3 and 5 of a busy op -> ignored; first
//     result is correct and only one done pulse is produced.
//  6. rst_n low in SHIFT cycle 4 -> busy=0, done=0, diff=0 immediately.
//     After release, a=0xAA b=0x55 -> diff=0x55, borrow_out=0.

Source files
------------

// File: rtl/serial_full_subtractor_if.sv
// serial_full_subtractor_if: start/busy/done handshake and operand/result bus of the bit-serial subtractor.
// Optional overflow flag present only when SERIAL_SUB_OVF_EN is defined.
interface serial_full_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic             overflow;
   modport master (
      output start, a, b, borrow_in,
      input  busy, done, diff, borrow_out, overflow
   );
   modport slave (
      input  start, a, b, borrow_in,
      output busy, done, diff, borrow_out, overflow
   );
`else
   modport master (
      output start, a, b, borrow_in,
      input  busy, done, diff, borrow_out
   );
   modport slave (
      input  start, a, b, borrow_in,
      output busy, done, diff, borrow_out
   );
`endif
endinterface

// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor: bit-serial a - b - borrow_in, LSB first, one full-subtractor cell plus borrow flop.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_full_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   serial_full_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, diff_q, res_nx;
   logic [CW-1:0]    cnt;
   logic             bflop, bout_q;
   logic             x, y, d, bnext;
   logic             accept, last;

   // full-subtractor cell fed by the operand LSBs and the running borrow
   assign x      = a_sr[0];
   assign y      = b_sr[0];
   assign d      = x ^ y ^ bflop;
   assign bnext  = (~x & y) | (~(x ^ y) & bflop);
   assign res_nx = {d, res_sr[WIDTH-1:1]};

   // a request is honoured in every state except SHIFT, which gives back-to-back from DONE
   assign accept = bus.start && (state != S_SHIFT);
   assign last   = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));

   // next-state selection; the unused encoding falls back to IDLE
   always_comb begin
      state_nx = accept ? S_SHIFT :
                 (state == S_SHIFT) ? (last ? S_DONE : S_SHIFT) : S_IDLE;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // operand capture on accept, one bit per cycle while shifting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         bflop  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sr   <= bus.a;
         b_sr   <= bus.b;
         bflop  <= bus.borrow_in;
         cnt    <= '0;
      end else if (state == S_SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_nx;
         bflop  <= bnext;
         cnt    <= cnt + CW'(1);
      end
   end

   // result registers load with the final bit so they are valid in the DONE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (last) begin
         diff_q <= res_nx;
         bout_q <= bnext;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb, b_msb, ovf_q;

   // operand sign bits are kept because the shift registers lose them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
      end else if (accept) begin
         a_msb <= bus.a[WIDTH-1];
         b_msb <= bus.b[WIDTH-1];
      end
   end

   // signed overflow: operands of opposite sign and result sign differs from the minuend
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ovf_q <= 1'b0;
      else if (last) ovf_q <= (a_msb != b_msb) && (d != a_msb);
   end

   assign bus.overflow = ovf_q;
`endif

   assign bus.busy       = (state == S_SHIFT);
   assign bus.done       = (state == S_DONE);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = bout_q;
endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb_serial_full_subtractor: directed and random checks of the bit-serial subtractor against an arithmetic model.
module tb_serial_full_subtractor;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic [W-1:0] last_diff = '0;

   serial_full_subtractor_if #(.WIDTH(W)) sfs ();

   serial_full_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sfs)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // plain integer subtraction; a negative result means a borrow out of the top bit
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      int r;
      r = int'(a) - int'(b) - int'(bin);
      return {r < 0, r[W-1:0]};
   endfunction

   // called at a negedge; request held across one rising edge
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      sfs.start     = 1'b1;
      sfs.a         = a;
      sfs.b         = b;
      sfs.borrow_in = bin;
      @(negedge clk);
      sfs.start     = 1'b0;
      sfs.a         = $urandom;
      sfs.b         = $urandom;
      sfs.borrow_in = 1'($urandom);
   endtask

   // starts one cycle after accept, returns at the negedge of the done cycle
   task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic bin, input bit inject);
      int k;
      int busy_cnt;
      logic [W:0] exp;
      exp = model(a, b, bin);
      k = 1;
      busy_cnt = 0;
      while (!sfs.done && k < 20) begin
         busy_cnt += int'(sfs.busy);
         sfs.start = inject && (k == 3 || k == 5);
         if (sfs.start) begin
            sfs.a = $urandom;
            sfs.b = $urandom;
            sfs.borrow_in = 1'($urandom);
         end
         @(negedge clk);
         sfs.start = 1'b0;
         k++;
      end
      check({tag, "_done"}, 32'(sfs.done), 32'd1);
      check({tag, "_latency"}, 32'(k), 32'(W + 1));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      check({tag, "_busy_in_done"}, 32'(sfs.busy), 32'd0);
      check({tag, "_diff"}, 32'(sfs.diff), 32'(exp[W-1:0]));
      check({tag, "_borrow"}, 32'(sfs.borrow_out), 32'(exp[W]));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(sfs.overflow), 32'((a[W-1] != b[W-1]) && (exp[W-1] != a[W-1])));
`endif
      last_diff = exp[W-1:0];
   endtask

   // one cycle after done with no new request: pulse gone, result held
   task automatic post_check(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(sfs.done), 32'd0);
      check({tag, "_idle_busy"}, 32'(sfs.busy), 32'd0);
      check({tag, "_held"}, 32'(sfs.diff), 32'(last_diff));
   endtask

   initial begin
      logic [W-1:0] ra, rb, na, nb;
      logic rbin, nbin;
      int extra;
      sfs.start = 1'b0;
      sfs.a = '0;
      sfs.b = '0;
      sfs.borrow_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(sfs.busy), 32'd0);
      check("rst_done", 32'(sfs.done), 32'd0);
      check("rst_diff", 32'(sfs.diff), 32'd0);
      check("rst_borrow", 32'(sfs.borrow_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(sfs.busy), 32'd0);

      issue(8'h05, 8'h03, 1'b0);
      wait_result("t1", 8'h05, 8'h03, 1'b0, 1'b0);
      check("t1_diff_const", 32'(sfs.diff), 32'h02);
      post_check("t1");

      issue(8'h03, 8'h05, 1'b0);
      wait_result("t2", 8'h03, 8'h05, 1'b0, 1'b0);
      check("t2_diff_const", 32'(sfs.diff), 32'hFE);
      check("t2_borrow_const", 32'(sfs.borrow_out), 32'd1);
      post_check("t2");

      issue(8'h80, 8'h01, 1'b0);
      wait_result("t3", 8'h80, 8'h01, 1'b0, 1'b0);
      check("t3_diff_const", 32'(sfs.diff), 32'h7F);
`ifdef SERIAL_SUB_OVF_EN
      check("t3_ovf_const", 32'(sfs.overflow), 32'd1);
`endif
      post_check("t3");

      issue(8'h00, 8'h00, 1'b1);
      wait_result("t4a", 8'h00, 8'h00, 1'b1, 1'b0);
      check("t4a_diff_const", 32'(sfs.diff), 32'hFF);
      issue(8'h10, 8'h01, 1'b0);
      wait_result("t4b", 8'h10, 8'h01, 1'b0, 1'b0);
      check("t4b_diff_const", 32'(sfs.diff), 32'h0F);
      post_check("t4b");

      issue(8'h9C, 8'h27, 1'b1);
      wait_result("t5", 8'h9C, 8'h27, 1'b1, 1'b1);
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         extra += int'(sfs.done) + int'(sfs.busy);
      end
      check("t5_no_extra_op", 32'(extra), 32'd0);
      check("t5_held", 32'(sfs.diff), 32'(last_diff));

      issue(8'h12, 8'h34, 1'b0);
      repeat (3) @(negedge clk);
      check("t6_pre_busy", 32'(sfs.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", 32'(sfs.busy), 32'd0);
      check("t6_rst_done", 32'(sfs.done), 32'd0);
      check("t6_rst_diff", 32'(sfs.diff), 32'd0);
      check("t6_rst_borrow", 32'(sfs.borrow_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(8'hAA, 8'h55, 1'b0);
      wait_result("t6", 8'hAA, 8'h55, 1'b0, 1'b0);
      check("t6_diff_const", 32'(sfs.diff), 32'h55);
      check("t6_borrow_const", 32'(sfs.borrow_out), 32'd0);
      post_check("t6");

      ra = $urandom;
      rb = $urandom;
      rbin = 1'($urandom);
      issue(ra, rb, rbin);
      for (int i = 0; i < 24; i++) begin
         wait_result("rand", ra, rb, rbin, 1'b0);
         if (i == 23) begin
            post_check("rand_end");
         end else begin
            if ($urandom_range(0, 1) == 0) post_check("rand_gap");
            na = $urandom;
            nb = $urandom;
            nbin = 1'($urandom);
            issue(na, nb, nbin);
            ra = na;
            rb = nb;
            rbin = nbin;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
